spu_desc_queue: RTL and testbench
=================================

// Module: spu_desc_queue
// PURPOSE
// - Successor to the single-entry SPU packet register. Pairs an SPIDR write (sid/pkt_id/src/dst tile)
//   with the following SPRR write (header/data addr+size) into one packet descriptor.
// - Stamps each descriptor with a wrapping transaction id and queues it in a DEPTH-entry FIFO.
// - Adds valid/ready handshakes, SID pairing check with sticky errors, and occupancy reporting.
// PARAMETERS
// DEPTH      4                           FIFO entries; power of 2, >=2
// SID_W      `NOU_SID_WIDTH              stream id width
// PKT_ID_W   `NOU_PKT_ID_WIDTH           packet id width
// TILE_W     `NOU_TILE_ID_WIDTH          tile id width (src and dst)
// HADDR_W    `NOU_PKT_HEADER_ADDR_WIDTH  header address width
// HSZ_W      `NOU_PKT_HEADER_SZ_WIDTH    header size width
// DADDR_W    `NOU_PKT_DATA_ADDR_WIDTH    data address width
// DSZ_W      `NOU_PKT_DATA_SZ_WIDTH      data size width
// TID_W      `NOU_TID_WIDTH              transaction id width
// PORTS
// clk             in   1                  clock; all state on posedge
// rstn            in   1                  asynchronous active-low reset
// spidr_vld/rdy   in/out 1                ID-register write handshake
// spidr_sid, spidr_pkt_id, spidr_src_tile_id, spidr_dst_tile_id  in  SID_W/PKT_ID_W/TILE_W/TILE_W
// sprr_vld/rdy    in/out 1                region-register write handshake
// sprr_sid, sprr_pkt_header_addr, sprr_pkt_header_sz, sprr_pkt_data_addr, sprr_pkt_data_sz  in  widths per params
// desc_vld        out  1                  head descriptor valid
// desc_rdy        in   1                  consumer accepts head
// desc_o          out  spu_desc_t         head descriptor {sid,pkt_id,src,dst,haddr,hsz,daddr,dsz,trans_id}
// occupancy       out  $clog2(DEPTH)+1    entries held
// err_sid_mismatch out 1                  sticky: SPRR sid != staged sid
// err_no_id       out  1                  sticky: SPRR accepted with no staged ID
// err_clr         in   1                  clears both sticky errors
// BEHAVIOUR
// - Reset (async, rstn=0): stage EMPTY, FIFO empty, trans_id=0, all outputs 0; spidr_rdy=1 after release.
// - Stage FSM: EMPTY --spidr fire--> HAVE_ID (ID fields latched); HAVE_ID --sprr fire--> EMPTY.
// - spidr_rdy = (stage==EMPTY). sprr_rdy = !fifo_full (no same-cycle pop credit). fire = vld & rdy.
// - sprr fire in HAVE_ID, sprr_sid==staged sid: push {staged ID, sprr fields, trans_id}; trans_id+=1.
// - sprr fire in HAVE_ID, sid differs: no push, stage->EMPTY, err_sid_mismatch<=1, trans_id unchanged.
// - sprr fire in EMPTY: no push, err_no_id<=1. Same-cycle spidr fire still latches (spidr then HAVE_ID).
// - trans_id wraps modulo 2^TID_W (all-ones -> 0), no flag.
// - desc_vld = !fifo_empty; desc_o = head, stable while desc_vld & !desc_rdy. Pop on desc_vld & desc_rdy.
// - Push and pop same cycle (not full): occupancy unchanged; one-entry FIFO: popped entry leaves and
//   new entry becomes head next cycle. Latency sprr fire -> desc_vld = 1 cycle (registered FIFO).
// - Full: sprr_rdy=0 until a pop is registered; pointers wrap at DEPTH with extra MSB for full/empty.
// - err_clr and a new error in the same cycle: the error wins (flag stays 1).
// - Reset mid-operation drops staged ID and all queued descriptors; no partial output.
// STRUCTURE
// - spu_pkg: spu_desc_t packed struct, spu_stage_e {EMPTY,HAVE_ID} enum, field-width localparams.
// - Sub-module spu_desc_fifo (generic DEPTH x $bits(spu_desc_t), vld/rdy both sides, occupancy).
// - Top holds stage FSM, staged ID regs, trans_id counter, error flags.
// TESTING
// - Reset, spidr sid=3 pkt=7, then sprr sid=3 -> desc_vld next cycle, desc_o fields match, trans_id=0.
// - 4 pairs with desc_rdy=0, DEPTH=4 -> occupancy=4, sprr_rdy=0; 5th sprr held; one pop -> accepted, tid=4.
// - spidr sid=3, sprr sid=5 -> no push, err_sid_mismatch=1, stage EMPTY; err_clr -> 0.
// - sprr with no spidr -> err_no_id=1, occupancy 0; simultaneous spidr+sprr from EMPTY -> err_no_id, ID staged.
// - TID_W=4: 17 good pairs -> trans_id sequence 0..15,0; desc_rdy=1 throughout, occupancy <=1.
// - rstn low with 3 queued + staged ID -> desc_vld=0, occupancy=0, spidr_rdy=1, next tid=0.

Source files
------------

// File: rtl/spu_desc_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module : spu_desc_queue_pkg
// Brief  : Field widths, descriptor struct and stage enum for the descriptor queue.
// Rev    : 1.0  initial release
// ============================================================================
package spu_desc_queue_pkg;

    localparam int c_sid_w    = 4;
    localparam int c_pkt_id_w = 8;
    localparam int c_tile_w   = 4;
    localparam int c_haddr_w  = 16;
    localparam int c_hsz_w    = 8;
    localparam int c_daddr_w  = 16;
    localparam int c_dsz_w    = 12;
    localparam int c_tid_w    = 4;

    typedef struct packed {
        logic [c_sid_w-1:0]    sid;
        logic [c_pkt_id_w-1:0] pkt_id;
        logic [c_tile_w-1:0]   src_tile_id;
        logic [c_tile_w-1:0]   dst_tile_id;
        logic [c_haddr_w-1:0]  pkt_header_addr;
        logic [c_hsz_w-1:0]    pkt_header_sz;
        logic [c_daddr_w-1:0]  pkt_data_addr;
        logic [c_dsz_w-1:0]    pkt_data_sz;
        logic [c_tid_w-1:0]    trans_id;
    } spu_desc_t;

    typedef enum logic [0:0] {
        EMPTY   = 1'b0,
        HAVE_ID = 1'b1
    } spu_stage_e;

endpackage
`default_nettype wire

// File: rtl/spu_desc_queue_if.sv
`default_nettype none
// ============================================================================
// Module : spu_desc_queue_if
// Brief  : SPIDR / SPRR write channels and descriptor output channel.
// Rev    : 1.0  initial release
// ============================================================================
interface spu_desc_queue_if;
    import spu_desc_queue_pkg::*;

    logic                  spidr_vld;
    logic                  spidr_rdy;
    logic [c_sid_w-1:0]    spidr_sid;
    logic [c_pkt_id_w-1:0] spidr_pkt_id;
    logic [c_tile_w-1:0]   spidr_src_tile_id;
    logic [c_tile_w-1:0]   spidr_dst_tile_id;

    logic                  sprr_vld;
    logic                  sprr_rdy;
    logic [c_sid_w-1:0]    sprr_sid;
    logic [c_haddr_w-1:0]  sprr_pkt_header_addr;
    logic [c_hsz_w-1:0]    sprr_pkt_header_sz;
    logic [c_daddr_w-1:0]  sprr_pkt_data_addr;
    logic [c_dsz_w-1:0]    sprr_pkt_data_sz;

    logic                  desc_vld;
    logic                  desc_rdy;
    spu_desc_t             desc_o;

    modport master (
        output spidr_vld, spidr_sid, spidr_pkt_id, spidr_src_tile_id, spidr_dst_tile_id,
        input  spidr_rdy,
        output sprr_vld, sprr_sid, sprr_pkt_header_addr, sprr_pkt_header_sz,
               sprr_pkt_data_addr, sprr_pkt_data_sz,
        input  sprr_rdy,
        input  desc_vld, desc_o,
        output desc_rdy
    );

    modport slave (
        input  spidr_vld, spidr_sid, spidr_pkt_id, spidr_src_tile_id, spidr_dst_tile_id,
        output spidr_rdy,
        input  sprr_vld, sprr_sid, sprr_pkt_header_addr, sprr_pkt_header_sz,
               sprr_pkt_data_addr, sprr_pkt_data_sz,
        output sprr_rdy,
        output desc_vld, desc_o,
        input  desc_rdy
    );

endinterface
`default_nettype wire

// File: rtl/spu_desc_queue_fifo.sv
`default_nettype none
// ============================================================================
// Module : spu_desc_queue_fifo
// Brief  : Generic registered FIFO, valid/ready on both sides, occupancy count.
// Rev    : 1.0  initial release
// ============================================================================
module spu_desc_queue_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  wire logic                     clk,
    input  wire logic                     rstn,
    input  wire logic                     in_vld,
    output logic                          in_rdy,
    input  wire logic [WIDTH-1:0]         in_data,
    output logic                          out_vld,
    input  wire logic                     out_rdy,
    output logic [WIDTH-1:0]              out_data,
    output logic [$clog2(DEPTH):0]        occupancy
);

    localparam int c_aw = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw:0]    r_wr_ptr;
    logic [c_aw:0]    r_rd_ptr;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;

    // Extra pointer MSB separates full (MSBs differ) from empty (all equal).
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                       (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
    assign in_rdy    = !w_full;
    assign out_vld   = !w_empty;
    assign w_push    = in_vld && !w_full;
    assign w_pop     = out_rdy && !w_empty;
    assign occupancy = r_wr_ptr - r_rd_ptr;
    assign out_data  = w_empty ? '0 : r_mem[r_rd_ptr[c_aw-1:0]];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[c_aw-1:0]] <= in_data;
    end

endmodule
`default_nettype wire

// File: rtl/spu_desc_queue.sv
`default_nettype none
// ============================================================================
// Module : spu_desc_queue
// Brief  : Pairs SPIDR and SPRR writes into tagged packet descriptors and queues them.
// Rev    : 1.0  initial release
// ============================================================================
module spu_desc_queue
    import spu_desc_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wire logic               clk,
    input  wire logic               rstn,
    spu_desc_queue_if.slave         bus,
    output logic [$clog2(DEPTH):0]  occupancy,
    output logic                    err_sid_mismatch,
    output logic                    err_no_id,
    input  wire logic               err_clr
);

    spu_stage_e             r_stage;
    spu_stage_e             w_stage_next;
    logic                   r_active;
    logic [c_sid_w-1:0]     r_sid;
    logic [c_pkt_id_w-1:0]  r_pkt_id;
    logic [c_tile_w-1:0]    r_src_tile_id;
    logic [c_tile_w-1:0]    r_dst_tile_id;
    logic [c_tid_w-1:0]     r_trans_id;
    logic                   w_fifo_in_rdy;
    logic                   w_spidr_fire;
    logic                   w_sprr_fire;
    logic                   w_push;
    logic                   w_mismatch;
    logic                   w_no_id;
    spu_desc_t              w_push_desc;
    logic [$bits(spu_desc_t)-1:0] w_head;

    // Ready outputs stay low while in reset and for the release cycle.
    assign bus.spidr_rdy = r_active && (r_stage == EMPTY);
    assign bus.sprr_rdy  = r_active && w_fifo_in_rdy;
    assign w_spidr_fire  = bus.spidr_vld && bus.spidr_rdy;
    assign w_sprr_fire   = bus.sprr_vld && bus.sprr_rdy;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_stage  <= EMPTY;
            r_active <= 1'b0;
        end else begin
            r_stage  <= w_stage_next;
            r_active <= 1'b1;
        end
    end

    always_comb begin
        w_stage_next = r_stage;
        w_push       = 1'b0;
        w_mismatch   = 1'b0;
        w_no_id      = 1'b0;
        case (r_stage)
            EMPTY: begin
                if (w_sprr_fire)  w_no_id      = 1'b1;
                if (w_spidr_fire) w_stage_next = HAVE_ID;
            end
            HAVE_ID: begin
                if (w_sprr_fire) begin
                    w_stage_next = EMPTY;
                    if (bus.sprr_sid == r_sid) w_push     = 1'b1;
                    else                       w_mismatch = 1'b1;
                end
            end
            default: w_stage_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sid            <= '0;
            r_pkt_id         <= '0;
            r_src_tile_id    <= '0;
            r_dst_tile_id    <= '0;
            r_trans_id       <= '0;
            err_sid_mismatch <= 1'b0;
            err_no_id        <= 1'b0;
        end else begin
            if (w_spidr_fire) begin
                r_sid         <= bus.spidr_sid;
                r_pkt_id      <= bus.spidr_pkt_id;
                r_src_tile_id <= bus.spidr_src_tile_id;
                r_dst_tile_id <= bus.spidr_dst_tile_id;
            end
            if (w_push) r_trans_id <= r_trans_id + 1'b1;
            // A new error in the clearing cycle keeps the flag set.
            if (w_mismatch)   err_sid_mismatch <= 1'b1;
            else if (err_clr) err_sid_mismatch <= 1'b0;
            if (w_no_id)      err_no_id <= 1'b1;
            else if (err_clr) err_no_id <= 1'b0;
        end
    end

    always_comb begin
        w_push_desc                 = '0;
        w_push_desc.sid             = r_sid;
        w_push_desc.pkt_id          = r_pkt_id;
        w_push_desc.src_tile_id     = r_src_tile_id;
        w_push_desc.dst_tile_id     = r_dst_tile_id;
        w_push_desc.pkt_header_addr = bus.sprr_pkt_header_addr;
        w_push_desc.pkt_header_sz   = bus.sprr_pkt_header_sz;
        w_push_desc.pkt_data_addr   = bus.sprr_pkt_data_addr;
        w_push_desc.pkt_data_sz     = bus.sprr_pkt_data_sz;
        w_push_desc.trans_id        = r_trans_id;
    end

    spu_desc_queue_fifo #(
        .WIDTH ($bits(spu_desc_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .in_vld    (w_push),
        .in_rdy    (w_fifo_in_rdy),
        .in_data   (w_push_desc),
        .out_vld   (bus.desc_vld),
        .out_rdy   (bus.desc_rdy),
        .out_data  (w_head),
        .occupancy (occupancy)
    );

    assign bus.desc_o = w_head;

endmodule
`default_nettype wire

// File: tb/tb_spu_desc_queue.sv
`default_nettype none
// ============================================================================
// Module : tb_spu_desc_queue
// Brief  : Directed self-checking bench for spu_desc_queue (DEPTH=4, 4-bit trans_id).
// Rev    : 1.0  initial release
// ============================================================================
module tb_spu_desc_queue;
    import spu_desc_queue_pkg::*;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       err_clr = 1'b0;
    logic [2:0] occupancy;
    logic       err_sid_mismatch;
    logic       err_no_id;
    int         checks = 0;
    int         failures = 0;

    spu_desc_queue_if bus ();

    spu_desc_queue #(.DEPTH(DEPTH)) dut (
        .clk              (clk),
        .rstn             (rstn),
        .bus              (bus),
        .occupancy        (occupancy),
        .err_sid_mismatch (err_sid_mismatch),
        .err_no_id        (err_no_id),
        .err_clr          (err_clr)
    );

    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.spidr_vld = 0; bus.spidr_sid = '0; bus.spidr_pkt_id = '0;
        bus.spidr_src_tile_id = '0; bus.spidr_dst_tile_id = '0;
        bus.sprr_vld = 0; bus.sprr_sid = '0; bus.sprr_pkt_header_addr = '0;
        bus.sprr_pkt_header_sz = '0; bus.sprr_pkt_data_addr = '0; bus.sprr_pkt_data_sz = '0;
        bus.desc_rdy = 0; err_clr = 0;
    endtask

    task automatic apply_reset();
        rstn = 0;
        idle_inputs();
        repeat (2) cycle();
        rstn = 1;
        cycle();
    endtask

    task automatic set_spidr(input logic [3:0] sid, input logic [7:0] pkt,
                             input logic [3:0] src, input logic [3:0] dst);
        bus.spidr_vld = 1; bus.spidr_sid = sid; bus.spidr_pkt_id = pkt;
        bus.spidr_src_tile_id = src; bus.spidr_dst_tile_id = dst;
    endtask

    task automatic set_sprr(input logic [3:0] sid, input logic [15:0] ha, input logic [7:0] hs,
                            input logic [15:0] da, input logic [11:0] ds);
        bus.sprr_vld = 1; bus.sprr_sid = sid; bus.sprr_pkt_header_addr = ha;
        bus.sprr_pkt_header_sz = hs; bus.sprr_pkt_data_addr = da; bus.sprr_pkt_data_sz = ds;
    endtask

    // One SPIDR write followed by the matching SPRR write, one cycle each.
    task automatic good_pair(input logic [3:0] sid, input logic [7:0] pkt);
        set_spidr(sid, pkt, 4'h1, 4'h2);
        cycle();
        bus.spidr_vld = 0;
        set_sprr(sid, {8'h00, pkt}, 8'h10, 16'h2000, 12'h040);
        cycle();
        bus.sprr_vld = 0;
    endtask

    function automatic spu_desc_t mk(input logic [3:0] sid, input logic [7:0] pkt,
                                     input logic [3:0] src, input logic [3:0] dst,
                                     input logic [15:0] ha, input logic [7:0] hs,
                                     input logic [15:0] da, input logic [11:0] ds,
                                     input logic [3:0] tid);
        spu_desc_t d;
        d.sid = sid; d.pkt_id = pkt; d.src_tile_id = src; d.dst_tile_id = dst;
        d.pkt_header_addr = ha; d.pkt_header_sz = hs; d.pkt_data_addr = da;
        d.pkt_data_sz = ds; d.trans_id = tid;
        return d;
    endfunction

    task automatic test_reset();
        rstn = 0;
        idle_inputs();
        #2;
        checks++; if (bus.desc_vld !== 1'b0) begin failures++; $display("FAIL rst_desc_vld got=%b exp=0", bus.desc_vld); end
        checks++; if (occupancy !== 3'd0) begin failures++; $display("FAIL rst_occupancy got=%0d exp=0", occupancy); end
        checks++; if (bus.spidr_rdy !== 1'b0 || bus.sprr_rdy !== 1'b0) begin failures++; $display("FAIL rst_rdys got=%b%b exp=00", bus.spidr_rdy, bus.sprr_rdy); end
        checks++; if (err_sid_mismatch !== 1'b0 || err_no_id !== 1'b0) begin failures++; $display("FAIL rst_errs got=%b%b exp=00", err_sid_mismatch, err_no_id); end
        checks++; if (bus.desc_o !== '0) begin failures++; $display("FAIL rst_desc_o got=%h exp=0", bus.desc_o); end
        repeat (2) cycle();
        rstn = 1;
        cycle();
        checks++; if (bus.spidr_rdy !== 1'b1 || bus.sprr_rdy !== 1'b1) begin failures++; $display("FAIL rel_rdys got=%b%b exp=11", bus.spidr_rdy, bus.sprr_rdy); end
    endtask

    task automatic test_basic();
        spu_desc_t exp;
        set_spidr(4'd3, 8'd7, 4'd1, 4'd2);
        cycle();
        bus.spidr_vld = 0;
        checks++; if (bus.spidr_rdy !== 1'b0 || bus.desc_vld !== 1'b0) begin failures++; $display("FAIL basic_staged got rdy=%b vld=%b exp rdy=0 vld=0", bus.spidr_rdy, bus.desc_vld); end
        set_sprr(4'd3, 16'h1234, 8'h20, 16'hABCD, 12'h100);
        cycle();
        bus.sprr_vld = 0;
        exp = mk(4'd3, 8'd7, 4'd1, 4'd2, 16'h1234, 8'h20, 16'hABCD, 12'h100, 4'd0);
        checks++; if (bus.desc_vld !== 1'b1 || occupancy !== 3'd1) begin failures++; $display("FAIL basic_vld got vld=%b occ=%0d exp vld=1 occ=1", bus.desc_vld, occupancy); end
        checks++; if (bus.desc_o !== exp) begin failures++; $display("FAIL basic_desc got=%h exp=%h", bus.desc_o, exp); end
        checks++; if (bus.spidr_rdy !== 1'b1) begin failures++; $display("FAIL basic_stage_empty got=%b exp=1", bus.spidr_rdy); end
        bus.desc_rdy = 1;
        cycle();
        bus.desc_rdy = 0;
        checks++; if (bus.desc_vld !== 1'b0 || occupancy !== 3'd0) begin failures++; $display("FAIL basic_pop got vld=%b occ=%0d exp vld=0 occ=0", bus.desc_vld, occupancy); end
    endtask

    task automatic test_full();
        apply_reset();
        for (int i = 0; i < 4; i++) good_pair(4'(i), 8'(8'h40 + i));
        checks++; if (occupancy !== 3'd4 || bus.sprr_rdy !== 1'b0) begin failures++; $display("FAIL full_occ got occ=%0d rdy=%b exp occ=4 rdy=0", occupancy, bus.sprr_rdy); end
        set_spidr(4'd5, 8'h45, 4'd1, 4'd2);
        cycle();
        bus.spidr_vld = 0;
        set_sprr(4'd5, 16'h0045, 8'h10, 16'h2000, 12'h040);
        cycle();
        checks++; if (occupancy !== 3'd4 || bus.spidr_rdy !== 1'b0) begin failures++; $display("FAIL full_held got occ=%0d spidr_rdy=%b exp occ=4 spidr_rdy=0", occupancy, bus.spidr_rdy); end
        checks++; if (bus.desc_o.trans_id !== 4'd0 || bus.desc_o.pkt_id !== 8'h40) begin failures++; $display("FAIL full_head got tid=%0d pkt=%h exp tid=0 pkt=40", bus.desc_o.trans_id, bus.desc_o.pkt_id); end
        bus.desc_rdy = 1;
        cycle();
        bus.desc_rdy = 0;
        checks++; if (occupancy !== 3'd3 || bus.sprr_rdy !== 1'b1) begin failures++; $display("FAIL full_pop got occ=%0d rdy=%b exp occ=3 rdy=1", occupancy, bus.sprr_rdy); end
        cycle();
        bus.sprr_vld = 0;
        checks++; if (occupancy !== 3'd4 || bus.sprr_rdy !== 1'b0 || bus.spidr_rdy !== 1'b1) begin failures++; $display("FAIL full_refill got occ=%0d sprr_rdy=%b spidr_rdy=%b exp 4/0/1", occupancy, bus.sprr_rdy, bus.spidr_rdy); end
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if (bus.desc_o.trans_id !== 4'(i) || bus.desc_o.sid !== ((i < 4) ? 4'(i) : 4'd5)) begin
                failures++; $display("FAIL full_drain%0d got tid=%0d sid=%0d exp tid=%0d sid=%0d", i, bus.desc_o.trans_id, bus.desc_o.sid, i, (i < 4) ? i : 5);
            end
            bus.desc_rdy = 1;
            cycle();
        end
        bus.desc_rdy = 0;
        checks++; if (bus.desc_vld !== 1'b0) begin failures++; $display("FAIL full_empty got=%b exp=0", bus.desc_vld); end
    endtask

    task automatic test_mismatch();
        set_spidr(4'd3, 8'h33, 4'd1, 4'd2);
        cycle();
        bus.spidr_vld = 0;
        set_sprr(4'd5, 16'h1111, 8'h11, 16'h2222, 12'h022);
        cycle();
        bus.sprr_vld = 0;
        checks++; if (occupancy !== 3'd0 || bus.desc_vld !== 1'b0) begin failures++; $display("FAIL mm_nopush got occ=%0d vld=%b exp 0/0", occupancy, bus.desc_vld); end
        checks++; if (err_sid_mismatch !== 1'b1 || err_no_id !== 1'b0) begin failures++; $display("FAIL mm_flags got mm=%b noid=%b exp 1/0", err_sid_mismatch, err_no_id); end
        checks++; if (bus.spidr_rdy !== 1'b1) begin failures++; $display("FAIL mm_stage got=%b exp=1", bus.spidr_rdy); end
        err_clr = 1;
        cycle();
        err_clr = 0;
        checks++; if (err_sid_mismatch !== 1'b0) begin failures++; $display("FAIL mm_clr got=%b exp=0", err_sid_mismatch); end
        set_spidr(4'd3, 8'h33, 4'd1, 4'd2);
        cycle();
        bus.spidr_vld = 0;
        set_sprr(4'd6, 16'h1111, 8'h11, 16'h2222, 12'h022);
        err_clr = 1;
        cycle();
        bus.sprr_vld = 0;
        err_clr = 0;
        checks++; if (err_sid_mismatch !== 1'b1) begin failures++; $display("FAIL mm_err_wins got=%b exp=1", err_sid_mismatch); end
        err_clr = 1;
        cycle();
        err_clr = 0;
        checks++; if (err_sid_mismatch !== 1'b0) begin failures++; $display("FAIL mm_clr2 got=%b exp=0", err_sid_mismatch); end
    endtask

    task automatic test_no_id();
        spu_desc_t exp;
        set_sprr(4'd2, 16'h0001, 8'h01, 16'h0002, 12'h003);
        cycle();
        bus.sprr_vld = 0;
        checks++; if (err_no_id !== 1'b1 || occupancy !== 3'd0) begin failures++; $display("FAIL noid_flag got err=%b occ=%0d exp 1/0", err_no_id, occupancy); end
        checks++; if (bus.spidr_rdy !== 1'b1 || err_sid_mismatch !== 1'b0) begin failures++; $display("FAIL noid_stage got rdy=%b mm=%b exp 1/0", bus.spidr_rdy, err_sid_mismatch); end
        err_clr = 1;
        cycle();
        err_clr = 0;
        checks++; if (err_no_id !== 1'b0) begin failures++; $display("FAIL noid_clr got=%b exp=0", err_no_id); end
        set_spidr(4'd9, 8'h99, 4'd3, 4'd4);
        set_sprr(4'd9, 16'h0001, 8'h01, 16'h0002, 12'h003);
        cycle();
        bus.spidr_vld = 0;
        bus.sprr_vld = 0;
        checks++; if (err_no_id !== 1'b1 || bus.spidr_rdy !== 1'b0 || occupancy !== 3'd0) begin failures++; $display("FAIL noid_simul got err=%b rdy=%b occ=%0d exp 1/0/0", err_no_id, bus.spidr_rdy, occupancy); end
        err_clr = 1;
        set_sprr(4'd9, 16'h5555, 8'h55, 16'h6666, 12'h066);
        cycle();
        bus.sprr_vld = 0;
        err_clr = 0;
        exp = mk(4'd9, 8'h99, 4'd3, 4'd4, 16'h5555, 8'h55, 16'h6666, 12'h066, 4'd5);
        checks++; if (bus.desc_o !== exp || bus.desc_vld !== 1'b1) begin failures++; $display("FAIL noid_staged_push got=%h vld=%b exp=%h vld=1", bus.desc_o, bus.desc_vld, exp); end
        checks++; if (err_no_id !== 1'b0) begin failures++; $display("FAIL noid_clr2 got=%b exp=0", err_no_id); end
        bus.desc_rdy = 1;
        cycle();
        bus.desc_rdy = 0;
    endtask

    task automatic test_tid_wrap();
        apply_reset();
        bus.desc_rdy = 1;
        for (int i = 0; i < 17; i++) begin
            good_pair(4'(i), 8'(i));
            checks++;
            if (bus.desc_vld !== 1'b1 || bus.desc_o.trans_id !== 4'(i) || occupancy !== 3'd1) begin
                failures++; $display("FAIL wrap%0d got vld=%b tid=%0d occ=%0d exp vld=1 tid=%0d occ=1", i, bus.desc_vld, bus.desc_o.trans_id, occupancy, i % 16);
            end
        end
        cycle();
        bus.desc_rdy = 0;
        checks++; if (occupancy !== 3'd0) begin failures++; $display("FAIL wrap_drain got=%0d exp=0", occupancy); end
    endtask

    task automatic test_reset_mid();
        spu_desc_t exp;
        for (int i = 0; i < 3; i++) good_pair(4'(i + 1), 8'(8'h60 + i));
        set_spidr(4'd7, 8'h77, 4'd1, 4'd2);
        cycle();
        bus.spidr_vld = 0;
        checks++; if (occupancy !== 3'd3 || bus.spidr_rdy !== 1'b0) begin failures++; $display("FAIL mid_pre got occ=%0d rdy=%b exp 3/0", occupancy, bus.spidr_rdy); end
        #2;
        rstn = 0;
        #1;
        checks++; if (bus.desc_vld !== 1'b0 || occupancy !== 3'd0) begin failures++; $display("FAIL mid_async got vld=%b occ=%0d exp 0/0", bus.desc_vld, occupancy); end
        idle_inputs();
        cycle();
        rstn = 1;
        cycle();
        checks++; if (bus.spidr_rdy !== 1'b1 || bus.desc_vld !== 1'b0) begin failures++; $display("FAIL mid_release got rdy=%b vld=%b exp 1/0", bus.spidr_rdy, bus.desc_vld); end
        good_pair(4'd1, 8'h11);
        exp = mk(4'd1, 8'h11, 4'd1, 4'd2, 16'h0011, 8'h10, 16'h2000, 12'h040, 4'd0);
        checks++; if (bus.desc_o !== exp) begin failures++; $display("FAIL mid_tid0 got=%h exp=%h", bus.desc_o, exp); end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_basic();
        test_full();
        test_mismatch();
        test_no_id();
        test_tid_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
